// File: rtl/rr_mux.sv
// rr_mux: N-to-1 round-robin arbitrated multiplexer with a registered output.
// Each cycle, the next valid channel at or after the round-robin pointer is
// granted. Its element is loaded into the output register and tagged with its
// source index.
//
// Handshake: a transfer happens on a channel at a rising edge when its
// valid and ready are both high. Valid never waits on ready. Ready may
// depend combinationally on valid. Data is sampled only at a transfer edge.
module rr_mux #(
    parameter int NUM_ELEM   = 6,
    parameter int ELEM_WIDTH = 8
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NUM_ELEM-1:0][ELEM_WIDTH-1:0] i_i,
    input  logic [NUM_ELEM-1:0]                 i_valid_i,
    output logic [NUM_ELEM-1:0]                 i_ready_o,
    output logic [ELEM_WIDTH-1:0]               o_o,
    output logic [$clog2(NUM_ELEM)-1:0]         o_s_o,
    output logic                                o_valid_o,
    input  logic                                o_ready_i
);

    localparam int SW = $clog2(NUM_ELEM);

    logic [SW-1:0] ptr;
    logic [SW-1:0] gnt;
    logic          found;
    logic          load;

    // The output register may take a new element when empty or being drained.
    assign load = !o_valid_o || o_ready_i;

    // Round-robin search starting at ptr, wrapping modulo NUM_ELEM.
    always_comb begin
        logic [SW:0]   sum;
        logic [SW-1:0] idx;
        found = 1'b0;
        gnt   = '0;
        sum   = '0;
        idx   = '0;
        for (int off = 0; off < NUM_ELEM; off++) begin
            sum = {1'b0, ptr} + (SW+1)'(off);
            if (sum >= (SW+1)'(NUM_ELEM)) begin
                sum = sum - (SW+1)'(NUM_ELEM);
            end
            idx = sum[SW-1:0];
            if (!found && i_valid_i[idx]) begin
                found = 1'b1;
                gnt   = idx;
            end
        end
    end

    // One-hot ready toward the granted channel, suppressed during reset.
    always_comb begin
        i_ready_o = '0;
        if (found && load && !rst_i) begin
            i_ready_o[gnt] = 1'b1;
        end
    end

    // Output register and pointer. The pointer advances only on a grant.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            o_valid_o <= 1'b0;
            o_o       <= '0;
            o_s_o     <= '0;
            ptr       <= '0;
        end else if (load) begin
            if (found) begin
                o_valid_o <= 1'b1;
                o_o       <= i_i[gnt];
                o_s_o     <= gnt;
                ptr       <= (gnt == SW'(NUM_ELEM - 1)) ? '0 : gnt + 1'b1;
            end else begin
                o_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_mux.sv
// Bench for rr_mux: a directed vector table, then a random phase against a
// reference arbiter model with an expected queue of {source, data}.
module tb_rr_mux;

    localparam int N  = 6;
    localparam int W  = 8;
    localparam int SW = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0][W-1:0]  i_data;
    logic [N-1:0]         i_valid;
    logic [N-1:0]         i_ready;
    logic [W-1:0]         o_data;
    logic [SW-1:0]        o_src;
    logic                 o_valid;
    logic                 o_ready;

    int total = 0;
    int bad   = 0;

    logic [SW+W-1:0] exp_q[$];

    typedef struct {
        logic          rst;
        logic [N-1:0]  valid;
        logic [W-1:0]  base;
        logic          ordy;
        logic [N-1:0]  exp_rdy;
        logic          exp_v;
        logic [W-1:0]  exp_d;
        logic [SW-1:0] exp_s;
    } vec_t;

    vec_t vecs[$];

    rr_mux #(.NUM_ELEM(N), .ELEM_WIDTH(W)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .i_i       (i_data),
        .i_valid_i (i_valid),
        .i_ready_o (i_ready),
        .o_o       (o_data),
        .o_s_o     (o_src),
        .o_valid_o (o_valid),
        .o_ready_i (o_ready)
    );

    // Clock: posedge at 5, 15, 25, ...
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_vec(input logic r, input logic [N-1:0] v, input logic [W-1:0] b,
                           input logic ordy, input logic [N-1:0] er, input logic ev,
                           input logic [W-1:0] ed, input logic [SW-1:0] es);
        vec_t t;
        t.rst = r; t.valid = v; t.base = b; t.ordy = ordy;
        t.exp_rdy = er; t.exp_v = ev; t.exp_d = ed; t.exp_s = es;
        vecs.push_back(t);
    endtask

    task automatic drive(input logic r, input logic [N-1:0] v, input logic [W-1:0] b, input logic ordy);
        rst     = r;
        i_valid = v;
        o_ready = ordy;
        for (int k = 0; k < N; k++) i_data[k] = b + W'(k);
    endtask

    // Reference arbiter state for the random phase.
    logic [SW-1:0] mdl_ptr;
    logic          mdl_v;

    initial begin
        drive(1'b1, '0, 8'h00, 1'b0);

        // Reset with all inputs valid: nothing accepted, outputs cleared.
        add_vec(1, 6'h3F, 8'h10, 1, 6'h00, 0, 8'h00, 0);
        add_vec(1, 6'h3F, 8'h10, 1, 6'h00, 0, 8'h00, 0);
        // First grant after release is channel 0.
        add_vec(0, 6'h3F, 8'h10, 1, 6'h01, 1, 8'h10, 0);
        // Single channel 3 carrying A5 (base A2 + 3), then drain holds data.
        add_vec(0, 6'h08, 8'hA2, 1, 6'h08, 1, 8'hA5, 3);
        add_vec(0, 6'h00, 8'hA2, 1, 6'h00, 0, 8'hA5, 3);
        // Re-reset, then fairness over two full rounds with wrap 5 -> 0.
        add_vec(1, 6'h00, 8'h10, 1, 6'h00, 0, 8'h00, 0);
        for (int i = 0; i < 12; i++) begin
            add_vec(0, 6'h3F, 8'h10, 1, 6'(1 << (i % N)), 1, 8'h10 + 8'(i % N), 3'(i % N));
        end
        // Load 8'h12 from channel 2, then stall for 5 cycles.
        add_vec(0, 6'h04, 8'h10, 1, 6'h04, 1, 8'h12, 2);
        for (int i = 0; i < 5; i++) add_vec(0, 6'h3F, 8'h10, 0, 6'h00, 1, 8'h12, 2);
        // Release: channel 3 replaces the held element with no bubble.
        add_vec(0, 6'h3F, 8'h10, 1, 6'h08, 1, 8'h13, 3);
        // Skip: ptr=4, channels 1 and 5 valid -> 5 first, then 1.
        add_vec(0, 6'h22, 8'h10, 1, 6'h20, 1, 8'h15, 5);
        add_vec(0, 6'h22, 8'h10, 1, 6'h02, 1, 8'h11, 1);
        // Drain, idle with o_ready low (empty register still loads).
        add_vec(0, 6'h00, 8'h10, 1, 6'h00, 0, 8'h11, 1);
        add_vec(0, 6'h00, 8'h10, 0, 6'h00, 0, 8'h11, 1);
        add_vec(0, 6'h01, 8'h10, 0, 6'h01, 1, 8'h10, 0);
        // Full and stalled: no grant, then reset discards the held element.
        add_vec(0, 6'h02, 8'h10, 0, 6'h00, 1, 8'h10, 0);
        add_vec(1, 6'h02, 8'h10, 0, 6'h00, 0, 8'h00, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].valid, vecs[i].base, vecs[i].ordy);
            #2;
            check($sformatf("vec%0d_ready", i), 32'(i_ready), 32'(vecs[i].exp_rdy));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_valid", i), 32'(o_valid), 32'(vecs[i].exp_v));
            check($sformatf("vec%0d_data", i), 32'(o_data), 32'(vecs[i].exp_d));
            check($sformatf("vec%0d_src", i), 32'(o_src), 32'(vecs[i].exp_s));
        end

        // Random phase, starting from reset (last table vector asserted it).
        mdl_ptr = '0;
        mdl_v   = 1'b0;
        exp_q.delete();
        for (int cyc = 0; cyc < 1010; cyc++) begin
            logic          found;
            logic [SW-1:0] g;
            logic          mload;
            logic [N-1:0]  erdy;
            logic [SW+W-1:0] item;
            @(negedge clk);
            rst = 1'b0;
            if (cyc < 1000) begin
                i_valid = N'($urandom_range(0, (1 << N) - 1));
                o_ready = ($urandom_range(0, 3) != 0);
            end else begin
                i_valid = '0;
                o_ready = 1'b1;
            end
            for (int k = 0; k < N; k++) i_data[k] = W'($urandom_range(0, 255));
            #2;
            found = 1'b0;
            g     = '0;
            for (int off = 0; off < N; off++) begin
                int idx;
                idx = (int'(mdl_ptr) + off) % N;
                if (!found && i_valid[idx]) begin
                    found = 1'b1;
                    g     = SW'(idx);
                end
            end
            mload = !mdl_v || o_ready;
            erdy  = (found && mload) ? N'(1 << g) : '0;
            check("rand_ready", 32'(i_ready), 32'(erdy));
            check("rand_valid", 32'(o_valid), 32'(mdl_v));
            if (mdl_v && o_ready) begin
                if (exp_q.size() == 0) begin
                    check("rand_queue_nonempty", 32'(0), 32'(1));
                end else begin
                    item = exp_q.pop_front();
                    check("rand_out", 32'({o_src, o_data}), 32'(item));
                end
            end
            if (mload) begin
                if (found) begin
                    exp_q.push_back({g, i_data[g]});
                    mdl_v   = 1'b1;
                    mdl_ptr = (g == SW'(N - 1)) ? '0 : g + 1'b1;
                end else begin
                    mdl_v = 1'b0;
                end
            end
            @(posedge clk);
        end
        check("rand_drained", 32'(exp_q.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_mux.md
Name: rr_mux

Overview:
- N-to-1 arbitrated multiplexer; the gathering counterpart of the datapath demux.
- Collects NUM_ELEM valid/ready input channels and forwards one element per cycle onto a single registered output channel.
- Tags each output element with its source index.
- Round-robin arbitration guarantees fairness. Used wherever several producers share one consumer, e.g. register-file write-back or a shared bus.

Parameters:
- NUM_ELEM, 6: number of input channels; must be >= 2; need not be a power of 2.
- ELEM_WIDTH, 8: data width of each element.

Ports:
- clk_i  input  1  clock; all logic is on the rising edge.
- rst_i  input  1  synchronous active-high reset, sampled on the rising edge of clk_i.
- i_i  input  [NUM_ELEM-1:0][ELEM_WIDTH-1:0]  per-channel input data.
- i_valid_i  input  NUM_ELEM  per-channel valid.
- i_ready_o  output  NUM_ELEM  per-channel ready; at most one bit high (one-hot or zero).
- o_o  output  ELEM_WIDTH  registered output data.
- o_s_o  output  $clog2(NUM_ELEM)  registered source index of o_o.
- o_valid_o  output  1  registered output valid.
- o_ready_i  input  1  downstream ready.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - o_valid_o=0, o_o='0, o_s_o='0, round-robin pointer ptr=0.
  - i_ready_o is forced to '0 while rst_i=1.
  - Reset mid-transfer discards the held output element; no input handshake completes in a cycle where rst_i=1.
- Load condition: load = !o_valid_o || o_ready_i. This is a single-stage pipeline register with full throughput of one element per cycle.
- Grant (combinational):
  - g = first index k with i_valid_i[k]=1, searching ptr, ptr+1, ..., NUM_ELEM-1, 0, ..., ptr-1 (mod NUM_ELEM, not mod 2^n).
  - i_ready_o[g] = load && rst_i==0; all other bits are 0.
  - If no valid input, i_ready_o='0.
- Input handshake on channel k: i_valid_i[k] && i_ready_o[k] at a rising edge.
- On an input handshake on channel g, at the next edge:
  - o_o <= i_i[g], o_s_o <= g, o_valid_o <= 1.
  - ptr <= (g==NUM_ELEM-1) ? 0 : g+1.
- Output handshake: o_valid_o && o_ready_i. If load is true but no input is valid, o_valid_o <= 0 (drain); o_o and o_s_o hold their last values.
- Stall: o_valid_o=1 and o_ready_i=0 means o_o, o_s_o, o_valid_o and ptr all hold, and i_ready_o='0.
- Simultaneous output handshake and new grant in the same cycle: the new element replaces the old one with no bubble.
- Latency: 1 cycle from input handshake to o_valid_o.
- ptr changes only on a grant.
- Inputs may drop i_valid_i without a handshake; the block must not depend on input valid being stable.
- Ordering: elements from one channel leave in arrival order. No element is duplicated or lost.
- Fairness: with all channels continuously valid and o_ready_i=1, grants cycle 0,1,...,NUM_ELEM-1,0,...
- Any channel that is continuously valid is granted within NUM_ELEM grants.

Test Plan:
- Reset: assert rst_i for 2 cycles with all inputs valid -> o_valid_o=0, o_o=0, o_s_o=0, i_ready_o=0; after release, first grant is channel 0.
- Single channel: i_valid_i=6'b001000, i_i[3]=8'hA5, o_ready_i=1 -> i_ready_o=6'b001000. Next cycle o_o=8'hA5, o_s_o=3, o_valid_o=1. Following cycle (input deasserted) o_valid_o=0.
- Fairness/wrap: all 6 channels valid, i_i[k]=8'h10+k, o_ready_i=1 for 12 cycles -> o_s_o sequence 0,1,2,3,4,5,0,1,...; ptr wraps from 5 to 0, never 6 or 7.
- Back-pressure: o_valid_o=1 holding 8'h12 from channel 2, o_ready_i=0 for 5 cycles -> o_o, o_s_o and o_valid_o stable, i_ready_o=0. Raise o_ready_i -> next element is from channel 3 with no bubble.
- Skip: ptr=4, only channels 1 and 5 valid -> grant order 5 then 1.
- Random: 1000 cycles with random valids, data and o_ready_i; a scoreboard of per-channel queues matches every (o_o, o_s_o). pass==total, fail==0 reported via result_print.
